speedo_gate_ctrl: RTL

//  Measurement sequencer for the speedometer datapath. Conditions the raw wheel

---
 rtl/speedo_gate_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/speedo_gate_ctrl.sv
// ---------------------------------------------------------------------------
// speedo_gate_ctrl
// Measurement sequencer for the speedometer datapath. The raw wheel pulse is
// synchronised, debounced and its filtered rising edges are counted over
// back-to-back gate windows of GATE_CYCLES clocks. Each finished window's count
// is offered to the display path over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   enable       1 = run gate windows, 0 = abort the current window and idle
//   pulse        raw asynchronous wheel pulse
//   speed        edges counted in the last completed window (saturated)
//   speed_valid  speed/overflow/dropped hold a result not yet accepted
//   speed_ready  downstream accepts the result when speed_valid & speed_ready
//   overflow     result saturated at 2**CNT_W-1
//   dropped      an earlier unaccepted result was overwritten (sticky to accept)
//   gate_active  high on every cycle of a counting window
// ---------------------------------------------------------------------------
module speedo_gate_ctrl #(
   parameter int unsigned GATE_CYCLES = 40_000_000,
   parameter int unsigned DEB_CYCLES  = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse,
   output logic [CNT_W-1:0] speed,
   output logic             speed_valid,
   input  logic             speed_ready,
   output logic             overflow,
   output logic             dropped,
   output logic             gate_active
);

   localparam int unsigned      GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned      DW        = $clog2(DEB_CYCLES) + 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0]    GATE_ZERO = {GW{1'b0}};
   localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
   localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [DW-1:0]    DEB_ZERO  = {DW{1'b0}};
   localparam logic [DW-1:0]    DEB_ONE   = DW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GATE = 1'b1
   } state_e;

   // Saturating increment: the edge counter sticks at all-ones, never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = CNT_MAX;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             filt_q, filt_d;
   logic             filt_prev_q, filt_prev_d;
   logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
   state_e           state_q, state_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] speed_q, speed_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             drop_q, drop_d;
   logic             gate_act_q, gate_act_d;

   logic             rise_s;
   logic             publish_s;
   logic             accept_s;
   logic [CNT_W-1:0] edge_inc_s;

   // Input conditioning: two-stage synchroniser and stability filter.
   always_comb begin
      sync1_d     = pulse;
      sync2_d     = sync1_q;
      filt_prev_d = filt_q;
      filt_d      = filt_q;
      deb_cnt_d   = DEB_ZERO;
      if (sync2_q != filt_q) begin
         // Accept the new level only after DEB_CYCLES consecutive disagreements.
         if (deb_cnt_q == DEB_LAST) begin
            filt_d    = sync2_q;
            deb_cnt_d = DEB_ZERO;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
         end
      end else begin
         deb_cnt_d = DEB_ZERO;
      end
   end

   // Count event is a registered 0->1 transition of the filtered level.
   assign rise_s     = filt_q & ~filt_prev_q;
   assign edge_inc_s = rise_s ? sat_inc(edge_cnt_q) : edge_cnt_q;

   // Gate sequencer: next state, window position and edge counter.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = GATE_ZERO;
      edge_cnt_d = CNT_ZERO;
      publish_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_GATE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GATE: begin
            if (gate_cnt_q == GATE_LAST) begin
               // Window complete (including an edge on its last cycle); the
               // next cycle already belongs to a fresh window.
               publish_s  = 1'b1;
               gate_cnt_d = GATE_ZERO;
               edge_cnt_d = CNT_ZERO;
            end else begin
               gate_cnt_d = gate_cnt_q + GATE_ONE;
               edge_cnt_d = edge_inc_s;
            end
            if (!enable) begin
               // Abort: any partial count is thrown away.
               state_d    = ST_IDLE;
               gate_cnt_d = GATE_ZERO;
               edge_cnt_d = CNT_ZERO;
            end else begin
               state_d = ST_GATE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      gate_act_d = (state_d == ST_GATE);
   end

   // Result register and valid/ready handshake with drop tracking.
   always_comb begin
      accept_s = valid_q & speed_ready;
      speed_d  = speed_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      drop_d   = drop_q;
      if (publish_s) begin
         speed_d = edge_inc_s;
         ovf_d   = (edge_inc_s == CNT_MAX);
         valid_d = 1'b1;
         // A result pending but not taken this cycle is being overwritten.
         if (accept_s) begin
            drop_d = 1'b0;
         end else begin
            drop_d = drop_q | valid_q;
         end
      end else if (accept_s) begin
         valid_d = 1'b0;
         drop_d  = 1'b0;
      end else begin
         valid_d = valid_q;
         drop_d  = drop_q;
      end
   end

   // State and data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         deb_cnt_q   <= DEB_ZERO;
         state_q     <= ST_IDLE;
         gate_cnt_q  <= GATE_ZERO;
         edge_cnt_q  <= CNT_ZERO;
         speed_q     <= CNT_ZERO;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= 1'b0;
         gate_act_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         deb_cnt_q   <= deb_cnt_d;
         state_q     <= state_d;
         gate_cnt_q  <= gate_cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         speed_q     <= speed_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
         gate_act_q  <= gate_act_d;
      end
   end

   assign speed       = speed_q;
   assign speed_valid = valid_q;
   assign overflow    = ovf_q;
   assign dropped     = drop_q;
   assign gate_active = gate_act_q;

endmodule
